// File: rtl/addsub_pkg.sv
// Shared helpers for the segmented pipelined adder/subtractor: stage count,
// triangular skew-register offsets, saturation constants and parameter checks.
package addsub_pkg;

  function automatic int seg_count(input int n, input int seg);
    return n / seg;
  endfunction

  // Bit offset of stage k's slice in the packed upper-operand skew bank.
  function automatic int up_off(input int n, input int seg, input int k);
    return k * n - (seg * k * (k + 1)) / 2;
  endfunction

  // Bit offset of stage k's slice in the packed partial-sum bank.
  function automatic int sum_off(input int seg, input int k);
    return (seg * k * (k + 1)) / 2;
  endfunction

  // Max-positive (neg=0) or min-negative (neg=1) constant for width n (n <= 64).
  function automatic logic [63:0] sat_const(input int n, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (n - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

  function automatic bit cfg_ok(input int n, input int m, input int seg);
    return (seg >= 1) && (n >= 2) && (n % seg == 0) && (m >= 2) && (m <= n) && (n <= 64);
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// SEG-bit ripple adder cell; also exposes the carry into its top bit so the
// final stage can form the signed-overflow flag.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);

  generate
    if (SEG == 1) begin : g_single
      assign c_msb = cin;
    end else begin : g_low
      // Top bit of this sum is the carry into bit SEG-1.
      logic [SEG-1:0] low;
      assign low = {1'b0, a_seg[SEG-2:0]} + {1'b0, b_seg[SEG-2:0]}
                 + {{(SEG-1){1'b0}}, cin};
      assign sum[SEG-2:0] = low[SEG-2:0];
      assign c_msb        = low[SEG-1];
    end
  endgenerate

  assign sum[SEG-1] = a_seg[SEG-1] ^ b_seg[SEG-1] ^ c_msb;
  assign cout       = (a_seg[SEG-1] & b_seg[SEG-1]) | (a_seg[SEG-1] & c_msb)
                    | (b_seg[SEG-1] & c_msb);

endmodule

// File: rtl/addsub_pipe_ext.sv
// Pipelined signed a +/- sign_extend(b), one SEG-bit carry segment per stage,
// valid/ready with global stall. Define ADDSUB_SAT_EN to clamp s on overflow.
module addsub_pipe_ext
  import addsub_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 8,
  parameter int SEG   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     s,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int STAGES = seg_count(N, SEG);
  localparam int UP_T   = up_off(N, SEG, STAGES - 1);
  localparam int UP_W   = (UP_T > 0) ? UP_T : 1;
  localparam int SUM_T  = sum_off(SEG, STAGES - 1);
  localparam int SUM_W  = (SUM_T > 0) ? SUM_T : 1;
  localparam int C_W    = (STAGES > 1) ? STAGES - 1 : 1;

  generate
    if (!cfg_ok(N, M, SEG)) begin : g_cfg_err
      $error("addsub_pipe_ext: need N%%SEG==0, 2<=M<=N, 2<=N<=64");
    end
  endgenerate

`ifdef ADDSUB_SAT_EN
  localparam logic [63:0]  MAX_POS64 = sat_const(N, 1'b0);
  localparam logic [63:0]  MIN_NEG64 = sat_const(N, 1'b1);
  localparam logic [N-1:0] MAX_POS   = MAX_POS64[N-1:0];
  localparam logic [N-1:0] MIN_NEG   = MIN_NEG64[N-1:0];
`endif

  logic             adv;
  logic [N-1:0]     ext_b;
  logic [N-1:0]     bx;
  logic [STAGES-1:0] v_reg;
  logic [UP_W-1:0]  a_up_reg, a_up_next;
  logic [UP_W-1:0]  bx_up_reg, bx_up_next;
  logic [SUM_W-1:0] sum_reg, sum_next;
  logic [C_W-1:0]   c_reg, c_next;
  logic [N-1:0]     s_next;
  logic             ovf_next;

  assign out_valid = v_reg[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  generate
    if (M == N) begin : g_no_ext
      assign ext_b = b;
    end else begin : g_ext
      assign ext_b = {{(N-M){b[M-1]}}, b};
    end
  endgenerate

  assign bx = ext_b ^ {N{sub}};

  // Stage gi adds segment gi; skew banks are packed triangles so every
  // register bit is consumed by the next stage.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stg
      logic [SEG-1:0] a_seg, b_seg, seg_sum;
      logic           cin, cout;

      if (gi == 0) begin : g_src0
        assign a_seg = a[SEG-1:0];
        assign b_seg = bx[SEG-1:0];
        assign cin   = sub;
      end else begin : g_srcn
        assign a_seg = a_up_reg[up_off(N, SEG, gi - 1) +: SEG];
        assign b_seg = bx_up_reg[up_off(N, SEG, gi - 1) +: SEG];
        assign cin   = c_reg[gi-1];
      end

      if (gi < STAGES - 1) begin : g_pass
        localparam int UO = up_off(N, SEG, gi);
        localparam int UW = N - (gi + 1) * SEG;
        localparam int SO = sum_off(SEG, gi);
        logic c_msb_unused;

        addsub_seg #(.SEG(SEG)) u_seg (
          .a_seg (a_seg),
          .b_seg (b_seg),
          .cin   (cin),
          .sum   (seg_sum),
          .cout  (cout),
          .c_msb (c_msb_unused)
        );

        assign c_next[gi] = cout;

        if (gi == 0) begin : g_first
          assign a_up_next[UO +: UW]  = a[N-1:SEG];
          assign bx_up_next[UO +: UW] = bx[N-1:SEG];
          assign sum_next[SO +: SEG]  = seg_sum;
        end else begin : g_mid
          localparam int UOP = up_off(N, SEG, gi - 1);
          localparam int SOP = sum_off(SEG, gi - 1);
          assign a_up_next[UO +: UW]  = a_up_reg[UOP + SEG +: UW];
          assign bx_up_next[UO +: UW] = bx_up_reg[UOP + SEG +: UW];
          assign sum_next[SO +: (gi + 1) * SEG] = {seg_sum, sum_reg[SOP +: gi * SEG]};
        end
      end else begin : g_last
        logic           c_msb;
        logic [N-1:0]   raw;

        addsub_seg #(.SEG(SEG)) u_seg (
          .a_seg (a_seg),
          .b_seg (b_seg),
          .cin   (cin),
          .sum   (seg_sum),
          .cout  (cout),
          .c_msb (c_msb)
        );

        if (gi == 0) begin : g_raw0
          assign raw = seg_sum;
        end else begin : g_rawn
          assign raw = {seg_sum, sum_reg[sum_off(SEG, gi - 1) +: gi * SEG]};
        end

        assign ovf_next = c_msb ^ cout;
`ifdef ADDSUB_SAT_EN
        // With overflow, cout=0 means both effective operands were positive.
        assign s_next = ovf_next ? (cout ? MIN_NEG : MAX_POS) : raw;
`else
        assign s_next = raw;
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg     <= '0;
      a_up_reg  <= '0;
      bx_up_reg <= '0;
      sum_reg   <= '0;
      c_reg     <= '0;
      s         <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      v_reg     <= STAGES'({v_reg, in_valid});
      a_up_reg  <= a_up_next;
      bx_up_reg <= bx_up_next;
      sum_reg   <= sum_next;
      c_reg     <= c_next;
      s         <= s_next;
      ovf       <= ovf_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
